// File: rtl/vga_sync_tracker_if.sv
// rtl/vga_sync_tracker_if.sv - sync inputs and regenerated timing outputs of the VGA sync tracker
interface vga_sync_tracker_if #(
    parameter int HW = 12,
    parameter int VW = 11
);
    logic          hsync_in;
    logic          vsync_in;
    logic          blank_in;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          active;
    logic          locked;
    logic          frame_start;
    logic          err;
    logic [HW-1:0] h_meas;
    logic [VW-1:0] v_meas;

    modport master (
        output hsync_in, vsync_in, blank_in,
        input  x, y, active, locked, frame_start, err, h_meas, v_meas
    );

    modport slave (
        input  hsync_in, vsync_in, blank_in,
        output x, y, active, locked, frame_start, err, h_meas, v_meas
    );
endinterface

// File: rtl/vga_sync_tracker.sv
// rtl/vga_sync_tracker.sv - VGA sink timing tracker: pixel coordinates, lock detection; VGA_TRACK_STATS_EN adds h_meas/v_meas
module vga_sync_tracker #(
    parameter int H_TOT       = 1344,
    parameter int V_TOT       = 806,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              vclock,
    input  logic              reset_n,
    vga_sync_tracker_if.slave vid
);
    localparam int HW   = $clog2(H_TOT) + 1;
    localparam int VW   = $clog2(V_TOT) + 1;
    localparam int HMAX = (1 << HW) - 1;
    localparam int WDOG = (2 * H_TOT > HMAX) ? HMAX : 2 * H_TOT;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t        state, state_n;
    logic          s_hsync, s_vsync, s_blank;
    logic          p_hsync, p_vsync, p_blank;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          primed, line_ok, y_pend;
    logic [3:0]    good_cnt, good_n;
    logic [HW-1:0] x_r;
    logic [VW-1:0] y_r;
    logic          active_r, locked_r, fs_r, err_r, err_n;

    logic          h_fall, v_fall, b_fall;
    logic [HW-1:0] line_len;
    logic [VW-1:0] frame_len;
    logic          line_bad, frame_good, wdog;

    assign h_fall    = p_hsync & ~s_hsync;
    assign v_fall    = p_vsync & ~s_vsync;
    assign b_fall    = p_blank & ~s_blank;
    assign line_len  = (hcnt == HW'(HMAX)) ? hcnt : hcnt + HW'(1);
    // A coincident hsync fall closes the last line of the ending frame.
    assign frame_len = vcnt + VW'(h_fall);
    assign line_bad  = h_fall && primed && (line_len != HW'(H_TOT));
    assign frame_good = primed && line_ok && !line_bad && (frame_len == VW'(V_TOT));
    assign wdog      = (hcnt == HW'(WDOG)) && !h_fall;

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        err_n   = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall && primed) begin
                    if (frame_good) begin
                        good_n = good_cnt + 4'd1;
                        if (good_n == 4'(LOCK_FRAMES))
                            state_n = LOCKED;
                    end else begin
                        good_n = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (v_fall && frame_len != VW'(V_TOT)) || wdog) begin
                    err_n   = 1'b1;
                    good_n  = 4'd0;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    // Blank samples reset to "blanked" so release never fakes a visible pixel.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            s_hsync  <= 1'b0;
            s_vsync  <= 1'b0;
            s_blank  <= 1'b1;
            p_hsync  <= 1'b0;
            p_vsync  <= 1'b0;
            p_blank  <= 1'b1;
            hcnt     <= '0;
            vcnt     <= '0;
            primed   <= 1'b0;
            line_ok  <= 1'b0;
            y_pend   <= 1'b0;
            good_cnt <= 4'd0;
            state    <= SEARCH;
            x_r      <= '0;
            y_r      <= '0;
            active_r <= 1'b0;
            locked_r <= 1'b0;
            fs_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            s_hsync  <= vid.hsync_in;
            s_vsync  <= vid.vsync_in;
            s_blank  <= vid.blank_in;
            p_hsync  <= s_hsync;
            p_vsync  <= s_vsync;
            p_blank  <= s_blank;

            if (h_fall)
                hcnt <= '0;
            else if (hcnt != HW'(HMAX))
                hcnt <= hcnt + HW'(1);

            if (v_fall)
                vcnt <= '0;
            else if (h_fall)
                vcnt <= vcnt + VW'(1);

            if (v_fall)
                primed <= 1'b1;

            if (v_fall)
                line_ok <= 1'b1;
            else if (line_bad)
                line_ok <= 1'b0;

            if (b_fall)
                x_r <= '0;
            else if (!s_blank)
                x_r <= x_r + HW'(1);

            if (b_fall)
                y_r <= y_pend ? '0 : y_r + VW'(1);

            if (v_fall)
                y_pend <= 1'b1;
            else if (b_fall)
                y_pend <= 1'b0;

            active_r <= ~s_blank;
            fs_r     <= v_fall;
            err_r    <= err_n;
            locked_r <= (state_n == LOCKED);
            state    <= state_n;
            good_cnt <= good_n;
        end
    end

`ifdef VGA_TRACK_STATS_EN
    logic [HW-1:0] h_meas_r;
    logic [VW-1:0] v_meas_r;

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            h_meas_r <= '0;
            v_meas_r <= '0;
        end else begin
            if (h_fall)
                h_meas_r <= line_len;
            if (v_fall)
                v_meas_r <= frame_len;
        end
    end

    assign vid.h_meas = h_meas_r;
    assign vid.v_meas = v_meas_r;
`else
    assign vid.h_meas = '0;
    assign vid.v_meas = '0;
`endif

    assign vid.x           = x_r;
    assign vid.y           = y_r;
    assign vid.active      = active_r;
    assign vid.locked      = locked_r;
    assign vid.frame_start = fs_r;
    assign vid.err         = err_r;
endmodule
